// File: rtl/matvec_pkg.sv
// Shared types and helpers for the parametrised matrix-vector multiplier.
// Saturation helper is only referenced when MATVEC_SAT_EN is defined.
package matvec_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, OUT} state_e;

  localparam int unsigned SAT_W = 64;

  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

  // Per-row cycle counter must reach N+1
  function automatic int unsigned cyc_w(input int unsigned n);
    return idx_w(n + 2);
  endfunction

  // Clamp a+b into a signed w-bit range (w < SAT_W)
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int unsigned w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi  = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
    lo  = ~hi;
    if (sum > hi) return SAT_W'(hi);
    if (sum < lo) return SAT_W'(lo);
    return SAT_W'(sum);
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Registered signed multiply-accumulate with synchronous clear.
// MATVEC_SAT_EN selects a sticky saturating accumulator instead of wrap-around.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int unsigned IW = 14,
  parameter int unsigned OW = 2*IW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 valid,
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  output logic signed [OW-1:0] acc
);

  logic signed [2*IW-1:0] prod;
  logic signed [OW-1:0]   acc_q, acc_d;

  assign prod = (2*IW)'(a) * (2*IW)'(b);
  assign acc  = acc_q;

`ifdef MATVEC_SAT_EN
  logic                    sat_q, sat_d;
  logic signed [SAT_W-1:0] sum_raw, sum_sat;

  // Once a row clips it holds its clipped value until cleared
  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    sum_raw = SAT_W'(acc_q) + SAT_W'(prod);
    sum_sat = sat_add(SAT_W'(acc_q), SAT_W'(prod), OW);
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (valid && !sat_q) begin
      acc_d = OW'(sum_sat);
      sat_d = (sum_sat != sum_raw);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end
`else
  always_comb begin
    acc_d = acc_q;
    if (clear)      acc_d = '0;
    else if (valid) acc_d = acc_q + OW'(prod);
  end

  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`endif

endmodule

// File: rtl/matvec_param.sv
// N x N signed matrix-vector multiplier with a reusable stored matrix.
// Optional saturating accumulation via MATVEC_SAT_EN (see matvec_mac).
module matvec_param
  import matvec_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 14,
  parameter int unsigned OW = 2*IW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [IW-1:0] input_data,
  input  logic                 new_matrix,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic signed [OW-1:0] output_data
);

  localparam int unsigned NN = N*N;
  localparam int unsigned AW = idx_w(NN);
  localparam int unsigned VW = idx_w(N);
  localparam int unsigned CW = cyc_w(N);

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [VW-1:0]        row_q, row_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic                 loaded_q, loaded_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_data_q, out_data_d;
  logic signed [IW-1:0] rd_m_q, rd_m_d, rd_x_q, rd_x_d;
  logic                 rd_v_q, rd_v_d;

  logic signed [IW-1:0] mat_mem [NN];
  logic signed [IW-1:0] vec_mem [N];

  logic                 mat_we, vec_we, mac_clear;
  logic [AW-1:0]        mat_raddr;
  logic                 in_fire, out_fire, last_m, last_v, cmp_done, last_row;
  logic signed [OW-1:0] acc;

  assign in_fire   = input_valid && in_ready_q;
  assign out_fire  = output_ready && out_valid_q;
  assign last_m    = (cnt_q == AW'(NN - 1));
  assign last_v    = (cnt_q == AW'(N - 1));
  assign cmp_done  = (cyc_q == CW'(N + 1));
  assign last_row  = (row_q == VW'(N - 1));
  assign mat_raddr = AW'(32'(row_q) * N + 32'(cyc_q));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_fire) state_d = new_matrix ? LOAD_M : LOAD_V;
      LOAD_M:  if (in_fire && last_m) state_d = LOAD_V;
      LOAD_V:  if (in_fire && last_v) state_d = COMPUTE;
      COMPUTE: if (cmp_done) state_d = OUT;
      OUT:     if (out_fire) state_d = last_row ? IDLE : COMPUTE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; the first packet element lands in IDLE
  always_comb begin
    cnt_d       = cnt_q;
    row_d       = row_q;
    cyc_d       = cyc_q;
    loaded_d    = loaded_q;
    out_data_d  = out_data_q;
    rd_m_d      = rd_m_q;
    rd_x_d      = rd_x_q;
    rd_v_d      = 1'b0;
    mat_we      = 1'b0;
    vec_we      = 1'b0;
    mac_clear   = 1'b0;
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD_M) || (state_d == LOAD_V);
    out_valid_d = (state_d == OUT);
    unique case (state_q)
      IDLE: if (in_fire) begin
        cnt_d  = AW'(1);
        mat_we = new_matrix;
        vec_we = !new_matrix;
      end
      LOAD_M: if (in_fire) begin
        mat_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (last_m) begin
          cnt_d    = '0;
          loaded_d = 1'b1;
        end
      end
      LOAD_V: if (in_fire) begin
        vec_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (last_v) begin
          cnt_d     = '0;
          row_d     = '0;
          cyc_d     = '0;
          mac_clear = 1'b1;
        end
      end
      COMPUTE: begin
        if (cmp_done) out_data_d = acc;
        else          cyc_d = cyc_q + CW'(1);
        if (cyc_q < CW'(N)) begin
          rd_v_d = 1'b1;
          rd_m_d = loaded_q ? mat_mem[mat_raddr] : '0;
          rd_x_d = vec_mem[cyc_q[VW-1:0]];
        end
      end
      OUT: if (out_fire && !last_row) begin
        row_d     = row_q + VW'(1);
        cyc_d     = '0;
        mac_clear = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      row_q       <= '0;
      cyc_q       <= '0;
      loaded_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_m_q      <= '0;
      rd_x_q      <= '0;
      rd_v_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      cyc_q       <= cyc_d;
      loaded_q    <= loaded_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_m_q      <= rd_m_d;
      rd_x_q      <= rd_x_d;
      rd_v_q      <= rd_v_d;
    end
  end

  // Element storage is not reset; validity is tracked by loaded_q
  always_ff @(posedge clk) begin
    if (mat_we) mat_mem[cnt_q] <= input_data;
    if (vec_we) vec_mem[cnt_q[VW-1:0]] <= input_data;
  end

  matvec_mac #(.IW(IW), .OW(OW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .valid (rd_v_q),
    .a     (rd_m_q),
    .b     (rd_x_q),
    .acc   (acc)
  );

  assign input_ready  = in_ready_q;
  assign output_valid = out_valid_q;
  assign output_data  = out_data_q;

endmodule

// File: tb/tb_matvec_param.sv
// Directed bench for matvec_param: table of packets with hand-computed results,
// plus reset, abort, latency and a small N=4 identity instance.
module tb_matvec_param;

  localparam int N  = 8;
  localparam int IW = 14;
  localparam int OW = 28;
`ifdef MATVEC_SAT_EN
  localparam int YSAT = 134217727;
`else
  localparam int YSAT = 0;
`endif

  typedef logic [0:N-1][IW-1:0] xvec_t;
  typedef logic [0:N-1][OW-1:0] yvec_t;
  typedef struct packed {
    logic [1:0] mat_sel;  // 0 reuse stored, 1 matrix A, 2 all -8192
    logic       gaps;
    logic [7:0] idle;
    xvec_t      x;
    yvec_t      y;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 input_valid, input_ready, new_matrix, output_valid, output_ready;
  logic signed [IW-1:0] input_data;
  logic signed [OW-1:0] output_data;

  logic                 in4_valid, in4_ready, nm4, out4_valid, out4_ready;
  logic signed [7:0]    in4_data;
  logic signed [15:0]   out4_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   entry_cyc = 0;
  rec_t tbl [7];
  int   x4 [4] = '{5, -7, 127, -128};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matvec_param #(.N(N), .IW(IW), .OW(OW)) u_dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .new_matrix(new_matrix), .output_valid(output_valid),
    .output_ready(output_ready), .output_data(output_data)
  );

  matvec_param #(.N(4), .IW(8), .OW(16)) u_dut4 (
    .clk(clk), .reset(reset), .input_valid(in4_valid), .input_ready(in4_ready),
    .input_data(in4_data), .new_matrix(nm4), .output_valid(out4_valid),
    .output_ready(out4_ready), .output_data(out4_data)
  );

  function automatic xvec_t xv(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {IW'(a0), IW'(a1), IW'(a2), IW'(a3), IW'(a4), IW'(a5), IW'(a6), IW'(a7)};
  endfunction

  function automatic yvec_t yv(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {OW'(a0), OW'(a1), OW'(a2), OW'(a3), OW'(a4), OW'(a5), OW'(a6), OW'(a7)};
  endfunction

  // Matrix A: M[r][k] = r - k, plus 100 on the diagonal
  function automatic logic signed [IW-1:0] mat_elem(input logic [1:0] sel, input int r, input int k);
    if (sel == 2'd2) return IW'(-8192);
    return IW'(r - k + ((r == k) ? 100 : 0));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  task automatic send_elem(input logic signed [IW-1:0] d, input logic nm, input bit gaps);
    int guard;
    while (gaps && $urandom_range(0, 2) == 0) begin
      input_valid = 1'b0;
      input_data  = 'x;
      @(negedge clk);
    end
    input_valid = 1'b1;
    input_data  = d;
    new_matrix  = nm;
    guard = 0;
    while (!input_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!input_ready) fail_now("input_ready_wait");
    @(posedge clk);
    @(negedge clk);
    entry_cyc   = cyc;
    input_valid = 1'b0;
    input_data  = 'x;
  endtask

  // Stream up to 'limit' elements; new_matrix is toggled after the first element
  task automatic send_packet(input logic [1:0] sel, input xvec_t x, input bit gaps, input int limit);
    int  n;
    logic first_nm;
    n = 0;
    first_nm = (sel != 2'd0);
    if (sel != 2'd0)
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++) begin
          if (n < limit) send_elem(mat_elem(sel, r, k), (n == 0) ? first_nm : !first_nm, gaps);
          n++;
        end
    for (int k = 0; k < N; k++) begin
      if (n < limit) send_elem($signed(x[k]), (n == 0) ? first_nm : !first_nm, gaps);
      n++;
    end
  endtask

  task automatic collect(input yvec_t y, input bit gaps, input int rec);
    int   t0, guard;
    logic signed [OW-1:0] snap;
    t0 = entry_cyc;
    for (int r = 0; r < N; r++) begin
      guard = 0;
      while (!output_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!output_valid) begin
        fail_now($sformatf("rec%0d row%0d output_valid_wait", rec, r));
        return;
      end
      if (!gaps) check($sformatf("rec%0d row%0d latency", rec, r), cyc - t0, N + 2);
      check($sformatf("rec%0d row%0d data", rec, r), output_data, $signed(y[r]));
      check($sformatf("rec%0d row%0d input_ready_low", rec, r), input_ready, 0);
      if (gaps) begin
        snap = output_data;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check($sformatf("rec%0d row%0d hold", rec, r), (output_valid && output_data == snap), 1);
      end
      output_ready = 1'b1;
      @(negedge clk);
      output_ready = 1'b0;
      t0 = cyc;
    end
  endtask

  task automatic after_packet(input int rec, input int idle);
    int bad;
    check($sformatf("rec%0d ready_after_last", rec), input_ready, 1);
    check($sformatf("rec%0d valid_after_last", rec), output_valid, 0);
    bad = 0;
    repeat (idle) begin
      @(negedge clk);
      if (output_valid) bad++;
    end
    check($sformatf("rec%0d idle_quiet", rec), bad, 0);
  endtask

  initial begin
    int idx, guard;
    reset = 1'b0;
    input_valid = 1'b0; input_data = '0; new_matrix = 1'b0; output_ready = 1'b0;
    in4_valid = 1'b0; in4_data = '0; nm4 = 1'b0; out4_ready = 1'b0;

    tbl[0] = '{mat_sel: 2'd1, gaps: 1'b0, idle: 8'd3,
               x: xv(-50, 40, 32, -16, 11, -49, 49, 111),
               y: yv(-5926, 3202, 2530, -2142, 686, -5186, 4742, 11070)};
    tbl[1] = '{mat_sel: 2'd0, gaps: 1'b0, idle: 8'd100,
               x: xv(22, -41, 42, 62, 4, -55, 7, -8),
               y: yv(2244, -4023, 4310, 6343, 576, -5291, 942, -525)};
    tbl[2] = '{mat_sel: 2'd1, gaps: 1'b1, idle: 8'd3,
               x: xv(-50, 40, 32, -16, 11, -49, 49, 111),
               y: yv(-5926, 3202, 2530, -2142, 686, -5186, 4742, 11070)};
    tbl[3] = '{mat_sel: 2'd2, gaps: 1'b0, idle: 8'd3,
               x: xv(-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192),
               y: yv(YSAT, YSAT, YSAT, YSAT, YSAT, YSAT, YSAT, YSAT)};
    tbl[4] = '{mat_sel: 2'd0, gaps: 1'b0, idle: 8'd3,
               x: xv(1, 1, 0, 0, 0, 0, 0, 0),
               y: yv(-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384)};
    tbl[5] = '{mat_sel: 2'd1, gaps: 1'b1, idle: 8'd3,
               x: xv(0, 0, 0, 1, 0, 0, 0, 0),
               y: yv(-3, -2, -1, 100, 1, 2, 3, 4)};
    tbl[6] = '{mat_sel: 2'd0, gaps: 1'b0, idle: 8'd3,
               x: xv(8191, -8192, 0, 0, 0, 0, 0, 0),
               y: yv(827292, -811009, 8190, 8189, 8188, 8187, 8186, 8185)};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset input_ready", input_ready, 0);
    check("reset output_valid", output_valid, 0);
    check("reset output_data", output_data, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", input_ready, 1);

    // No matrix loaded yet: reuse packet yields zeros
    send_packet(2'd0, xv(1, 1, 1, 1, 1, 1, 1, 1), 1'b0, 1000);
    collect('0, 1'b0, 100);
    after_packet(100, 3);

    // N=4, IW=8 identity instance
    check("dut4 ready", in4_ready, 1);
    for (int e = 0; e < 20; e++) begin
      in4_valid = 1'b1;
      nm4       = (e == 0);
      in4_data  = (e < 16) ? (((e / 4) == (e % 4)) ? 8'sd1 : 8'sd0) : 8'(x4[e - 16]);
      @(negedge clk);
    end
    in4_valid  = 1'b0;
    out4_ready = 1'b1;
    idx = 0;
    guard = 0;
    while (idx < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (out4_valid) begin
        check($sformatf("dut4 row%0d identity", idx), out4_data, x4[idx]);
        idx++;
      end
    end
    if (idx < 4) fail_now("dut4 output_valid_wait");
    out4_ready = 1'b0;

    // Table-driven packets
    for (int i = 0; i < 7; i++) begin
      send_packet(tbl[i].mat_sel, tbl[i].x, tbl[i].gaps, 1000);
      collect(tbl[i].y, tbl[i].gaps, i);
      after_packet(i, int'(tbl[i].idle));
    end

    // Abort a matrix load after 30 elements
    send_packet(2'd2, xv(1, 1, 1, 1, 1, 1, 1, 1), 1'b0, 30);
    reset = 1'b0;
    @(negedge clk);
    check("midreset input_ready", input_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset ready_after", input_ready, 1);
    send_packet(2'd0, xv(1, 1, 1, 1, 1, 1, 1, 1), 1'b0, 1000);
    collect('0, 1'b0, 200);
    after_packet(200, 3);
    send_packet(tbl[0].mat_sel, tbl[0].x, 1'b0, 1000);
    collect(tbl[0].y, 1'b0, 201);
    after_packet(201, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
